alu_sequencer: RTL and testbench

//  Parametrised, clocked successor to the combinational ALU front end.
//  - Accepts one request per start pulse; the request is an operand pair plus one-hot-style op flags.
//  - Add/Sub complete in one cycle; Mul (shift-add) and Div (restoring, unsigned) are iterative, one bit per cycle.
//  - Reports completion with a done pulse; sits between the control unit and the register file write-back path.

---
 rtl/alu_sequencer.sv | 93 +++++++++
 tb/tb_alu_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: clocked add/sub (single cycle) and iterative shift-add mul / restoring div unit
module alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Mul,
  input  logic             Div,
  output logic [WIDTH-1:0] Answer,
  output logic [WIDTH-1:0] Hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  typedef enum logic [2:0] {IDLE, ALU1, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, op_b;
  logic is_sub, accept, op_mul, op_div, last;
  logic [WIDTH:0] add_r, sub_r, mul_sum, div_sh, div_diff;
  always_comb begin
    accept = state == IDLE && start && (Add || Sub || Mul || Div);
    op_mul = !Add && !Sub && Mul;
    op_div = !Add && !Sub && !Mul && Div;
    last = cnt == CNT_W'(WIDTH);
    add_r = {1'b0, acc_lo} + {1'b0, op_b};
    sub_r = {1'b0, acc_lo} - {1'b0, op_b};
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    div_sh = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, op_b};
    state_n = state;
    case (state)
      IDLE: state_n = !accept ? IDLE : op_mul ? MUL : !op_div ? ALU1 : B == '0 ? DONE : DIV;
      ALU1: state_n = DONE;
      MUL, DIV: state_n = last ? DONE : state;
      default: state_n = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  // acc_hi:acc_lo hold partial product (mul) or remainder:quotient (div); op_b is multiplicand/divisor
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_b <= '0;
      is_sub <= 1'b0;
      Answer <= '0;
      Hi <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          cnt <= '0;
          acc_hi <= '0;
          is_sub <= !Add;
          acc_lo <= op_mul ? B : A;
          op_b <= op_mul ? A : B;
          div_zero <= op_div && B == '0;
          if (op_div && B == '0) begin
            Answer <= '1;
            Hi <= A;
          end
        end
        ALU1: begin
          Answer <= is_sub ? sub_r[WIDTH-1:0] : add_r[WIDTH-1:0];
          Hi <= WIDTH'(is_sub ? sub_r[WIDTH] : add_r[WIDTH]);
        end
        MUL: if (last) {Hi, Answer} <= {acc_hi, acc_lo};
        else begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        DIV: if (last) {Hi, Answer} <= {acc_hi, acc_lo};
        else begin
          acc_hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], !div_diff[WIDTH]};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed stimulus against a latency/arithmetic reference model
module tb_alu_sequencer;
  localparam int W = 32;
  logic clk = 0, reset = 1, start = 0, Add = 0, Sub = 0, Mul = 0, Div = 0;
  logic [W-1:0] A = '0, B = '0, Answer, Hi;
  logic busy, done, div_zero;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  alu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .Add(Add), .Sub(Sub), .Mul(Mul), .Div(Div),
    .Answer(Answer), .Hi(Hi), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: t counts cycles since accept, lat is the op latency
  bit m_act = 0, m_dz = 0, p_dz = 0;
  int m_t = 0, m_lat = 0;
  logic [W-1:0] m_ans = '0, m_hi = '0, p_ans = '0, p_hi = '0;
  logic [63:0] wide;
  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_t = 0; m_ans = '0; m_hi = '0; m_dz = 0;
    end else begin
      if (m_act && m_t == m_lat) m_act = 0;
      else if (m_act) m_t++;
      else if (start && (Add || Sub || Mul || Div)) begin
        m_act = 1; m_t = 1; m_dz = 0; p_dz = 0;
        if (Add) begin
          wide = {32'b0, A} + {32'b0, B};
          p_ans = wide[31:0]; p_hi = {31'b0, wide[32]}; m_lat = 2;
        end else if (Sub) begin
          p_ans = A - B; p_hi = {31'b0, A < B}; m_lat = 2;
        end else if (Mul) begin
          wide = {32'b0, A} * {32'b0, B};
          p_ans = wide[31:0]; p_hi = wide[63:32]; m_lat = W + 2;
        end else if (B == 0) begin
          p_ans = '1; p_hi = A; p_dz = 1; m_lat = 1;
        end else begin
          p_ans = A / B; p_hi = A % B; m_lat = W + 2;
        end
      end
      if (m_act && m_t == m_lat) begin
        m_ans = p_ans; m_hi = p_hi; m_dz = p_dz;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy", {63'b0, busy}, {63'b0, m_act});
    chk("done", {63'b0, done}, {63'b0, m_act && m_t == m_lat});
    chk("Answer", {32'b0, Answer}, {32'b0, m_ans});
    chk("Hi", {32'b0, Hi}, {32'b0, m_hi});
    chk("div_zero", {63'b0, div_zero}, {63'b0, m_dz});
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100 && busy; i++) @(negedge clk);
    if (i == 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] f, input logic [W-1:0] ea, input logic [W-1:0] eh,
                        input logic edz, input int elat, input int poke);
    int k;
    wait_idle();
    start = 1; A = a; B = b; {Add, Sub, Mul, Div} = f;
    @(negedge clk);
    start = 0; A = $urandom; B = $urandom; {Add, Sub, Mul, Div} = 4'($urandom);
    for (k = 1; k <= 100; k++) begin
      if (done) break;
      start = (k == poke);
      if (k == poke) {Add, Sub, Mul, Div} = 4'b0100;
      @(negedge clk);
    end
    start = 0;
    chk({nm, "_latency"}, 64'(k), 64'(elat));
    chk({nm, "_answer"}, {32'b0, Answer}, {32'b0, ea});
    chk({nm, "_hi"}, {32'b0, Hi}, {32'b0, eh});
    chk({nm, "_divzero"}, {63'b0, div_zero}, {63'b0, edz});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    chk_en = 1;
    chk("reset_answer", {32'b0, Answer}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    run_op("add", 6, 5, 4'b1000, 11, 0, 0, 2, 0);
    run_op("add_carry", 32'hFFFFFFFF, 1, 4'b1000, 0, 1, 0, 2, 0);
    run_op("sub_borrow", 5, 6, 4'b0100, 32'hFFFFFFFF, 1, 0, 2, 0);
    run_op("mul", 6, 5, 4'b0010, 30, 0, 0, 34, 0);
    run_op("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 1, 32'hFFFFFFFE, 0, 34, 0);
    run_op("div", 100, 7, 4'b0001, 14, 2, 0, 34, 0);
    run_op("div_zero", 5, 0, 4'b0001, 32'hFFFFFFFF, 5, 1, 1, 0);
    run_op("add_prio", 6, 5, 4'b1010, 11, 0, 0, 2, 0);
    run_op("mul_poke", 7, 9, 4'b0010, 63, 0, 0, 34, 10);
    @(negedge clk);
    chk("single_done", {63'b0, done}, 64'd0);
    wait_idle();
    start = 1; A = 1000; B = 3; {Add, Sub, Mul, Div} = 4'b0001;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_answer", {32'b0, Answer}, 64'd0);
    chk("rst_hi", {32'b0, Hi}, 64'd0);
    run_op("add_after_rst", 6, 5, 4'b1000, 11, 0, 0, 2, 0);
    for (int i = 0; i < 1500; i++) begin
      reset = $urandom_range(0, 199) == 0;
      start = $urandom_range(0, 3) == 0;
      {Add, Sub, Mul, Div} = 4'($urandom);
      A = $urandom_range(0, 1) ? $urandom : W'($urandom_range(0, 20));
      B = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 3)) : $urandom;
      @(negedge clk);
    end
    reset = 0; start = 0;
    wait_idle();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
